// File: rtl/scandoubler.sv
`default_nettype none
// ============================================================================
//  Module      : scandoubler
//  Description : Line doubler that turns 15 kHz native-rate video into
//                31 kHz video on the same clock. Each input line is stored
//                in one half of a ping-pong line buffer while the other half
//                (the previous complete line) is replayed twice at double
//                pixel rate. The second replay can be darkened to imitate
//                CRT scanlines.
//
//  Ports       :
//    clk_sys              core clock
//    reset                asynchronous, active-high reset
//    ce_x1                input pixel enable (native rate)
//    ce_x2                output pixel enable (2x ce_x1, coincident with it)
//    scanlines[1:0]       0 off, 1 = 25 % dim, 2 = 50 % dim, 3 = 75 % dim
//    R_in/G_in/B_in[5:0]  input colour, sampled on ce_x1
//    HSync_in, VSync_in   input syncs, active-low
//    R_out/G_out/B_out    doubled colour, registered
//    HSync_out, VSync_out doubled syncs, active-low, registered
//
//  Revision    : 1.0  initial release
// ============================================================================
module scandoubler #(
  parameter int LINE_AW = 10
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ce_x1,
  input  logic       ce_x2,
  input  logic [1:0] scanlines,
  input  logic [5:0] R_in,
  input  logic [5:0] G_in,
  input  logic [5:0] B_in,
  input  logic       HSync_in,
  input  logic       VSync_in,
  output logic [5:0] R_out,
  output logic [5:0] G_out,
  output logic [5:0] B_out,
  output logic       HSync_out,
  output logic       VSync_out
);

  localparam logic [LINE_AW-1:0] c_CNT_MAX = {LINE_AW{1'b1}};
  localparam logic [LINE_AW-1:0] c_ONE     = LINE_AW'(1);
  localparam logic [LINE_AW:0]   c_ONE_W   = (LINE_AW+1)'(1);
  localparam int                 c_DEPTH   = 2 ** (LINE_AW + 1);

  // --------------------------------------------------------------------------
  // Input side: sync edge detection, pixel counting, line measurement
  // --------------------------------------------------------------------------
  logic               r_hs_prev;
  logic               w_hs_fall;
  logic               w_hs_rise;
  logic [LINE_AW-1:0] r_hcnt;
  logic [LINE_AW-1:0] r_line_len;
  logic [LINE_AW-1:0] r_hs_len;
  logic [LINE_AW-1:0] r_hs_width;
  logic               r_bank;
  logic               r_seen_fall;
  logic               r_valid;

  assign w_hs_fall = ce_x1 & r_hs_prev & ~HSync_in;
  assign w_hs_rise = ce_x1 & ~r_hs_prev & HSync_in;

  // The pixel that carries the sync falling edge is pixel 0 of the new line
  // and is written straight into the new bank, so after that pixel the
  // counter holds 1 and r_hcnt always equals the pixel count of the line so
  // far. The counter saturates at c_CNT_MAX, which is also the largest
  // measurable line length.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_hs_prev   <= 1'b1;
      r_hcnt      <= '0;
      r_line_len  <= '0;
      r_bank      <= 1'b0;
      r_seen_fall <= 1'b0;
      r_valid     <= 1'b0;
    end else if (ce_x1) begin
      r_hs_prev <= HSync_in;
      if (w_hs_fall) begin
        r_line_len  <= r_hcnt;
        r_hcnt      <= c_ONE;
        r_bank      <= ~r_bank;
        r_seen_fall <= 1'b1;
        // The first falling edge after reset only opens a line; the second
        // one closes the first fully measured line.
        if (r_seen_fall) begin
          r_valid <= 1'b1;
        end
      end else if (r_hcnt != c_CNT_MAX) begin
        r_hcnt <= r_hcnt + c_ONE;
      end
    end
  end

  // Sync pulse width in input pixels, captured when the pulse ends.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_hs_len   <= '0;
      r_hs_width <= '0;
    end else if (ce_x1) begin
      if (w_hs_fall) begin
        r_hs_len <= c_ONE;
      end else if (!HSync_in && (r_hs_len != c_CNT_MAX)) begin
        r_hs_len <= r_hs_len + c_ONE;
      end
      if (w_hs_rise) begin
        r_hs_width <= r_hs_len;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Line buffer write port
  // --------------------------------------------------------------------------
  logic               w_wr_bank;
  logic [LINE_AW-1:0] w_wr_addr;
  logic               w_wr_en;

  assign w_wr_bank = w_hs_fall ? ~r_bank : r_bank;
  assign w_wr_addr = w_hs_fall ? '0 : r_hcnt;
  // The top address is never written: a saturated counter means overrun.
  assign w_wr_en   = ce_x1 & (w_wr_addr != c_CNT_MAX);

  // --------------------------------------------------------------------------
  // Output side: replay counter
  // --------------------------------------------------------------------------
  logic [LINE_AW-1:0] r_sd_hcnt;
  logic               r_sd_line;
  logic               r_vs_line;
  logic [LINE_AW:0]   w_sd_next;
  logic               w_sd_wrap;

  assign w_sd_next = {1'b0, r_sd_hcnt} + c_ONE_W;
  assign w_sd_wrap = (w_sd_next >= {1'b0, r_line_len});

  // A new input line restarts the replay from its first pixel even if the
  // previous replay has not finished; that also resolves a coincident wrap.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_sd_hcnt <= '0;
      r_sd_line <= 1'b0;
      r_vs_line <= 1'b1;
    end else if (ce_x2) begin
      if (w_hs_fall) begin
        r_sd_hcnt <= '0;
        r_sd_line <= 1'b0;
        r_vs_line <= VSync_in;
      end else if (w_sd_wrap) begin
        r_sd_hcnt <= '0;
        r_sd_line <= ~r_sd_line;
        r_vs_line <= VSync_in;
      end else begin
        r_sd_hcnt <= w_sd_next[LINE_AW-1:0];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Line buffer storage with synchronous read of the opposite bank
  // --------------------------------------------------------------------------
  logic [17:0] r_mem [c_DEPTH];
  logic [17:0] r_rd_data;

  always_ff @(posedge clk_sys) begin
    if (w_wr_en) begin
      r_mem[{w_wr_bank, w_wr_addr}] <= {R_in, G_in, B_in};
    end
    if (ce_x2) begin
      r_rd_data <= r_mem[{~r_bank, r_sd_hcnt}];
    end
  end

  // --------------------------------------------------------------------------
  // Pipeline stage 1: sideband travelling alongside the buffer read
  // --------------------------------------------------------------------------
  logic r_p1_line;
  logic r_p1_hs;
  logic r_p1_vs;
  logic r_p1_valid;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_p1_line  <= 1'b0;
      r_p1_hs    <= 1'b1;
      r_p1_vs    <= 1'b1;
      r_p1_valid <= 1'b0;
    end else if (ce_x2) begin
      r_p1_line  <= r_sd_line;
      r_p1_hs    <= (r_sd_hcnt >= r_hs_width);
      r_p1_vs    <= r_vs_line;
      r_p1_valid <= r_valid;
    end
  end

  // --------------------------------------------------------------------------
  // Pipeline stage 2: scanline darkening and output registers
  // --------------------------------------------------------------------------
  function automatic logic [5:0] f_dim(input logic [5:0] x,
                                       input logic       rep,
                                       input logic [1:0] mode);
    logic [5:0] y;
    y = x;
    if (rep) begin
      case (mode)
        2'd1:    y = (x >> 1) + (x >> 2);
        2'd2:    y = x >> 1;
        2'd3:    y = x >> 2;
        default: y = x;
      endcase
    end
    return y;
  endfunction

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      R_out     <= '0;
      G_out     <= '0;
      B_out     <= '0;
      HSync_out <= 1'b1;
      VSync_out <= 1'b1;
    end else if (ce_x2) begin
      if (r_p1_valid) begin
        R_out     <= f_dim(r_rd_data[17:12], r_p1_line, scanlines);
        G_out     <= f_dim(r_rd_data[11:6],  r_p1_line, scanlines);
        B_out     <= f_dim(r_rd_data[5:0],   r_p1_line, scanlines);
        HSync_out <= r_p1_hs;
        VSync_out <= r_p1_vs;
      end else begin
        R_out     <= '0;
        G_out     <= '0;
        B_out     <= '0;
        HSync_out <= 1'b1;
        VSync_out <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_scandoubler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_scandoubler
//  Description : Self-checking bench for scandoubler. Whole input lines are
//                driven; at each line start the expected replay of the
//                previous line is queued with its output cycle number and
//                compared when that cycle arrives.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_scandoubler;

  localparam int LINE_AW = 10;
  localparam int MAXLEN  = (1 << LINE_AW) - 1;
  localparam int HS_W    = 30;

  logic       clk_sys = 1'b0;
  logic       reset;
  logic       ce_x1;
  logic       ce_x2;
  logic [1:0] scanlines;
  logic [5:0] R_in, G_in, B_in;
  logic       HSync_in, VSync_in;
  logic [5:0] R_out, G_out, B_out;
  logic       HSync_out, VSync_out;

  always #5 clk_sys = ~clk_sys;

  scandoubler #(.LINE_AW(LINE_AW)) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .ce_x1     (ce_x1),
    .ce_x2     (ce_x2),
    .scanlines (scanlines),
    .R_in      (R_in),
    .G_in      (G_in),
    .B_in      (B_in),
    .HSync_in  (HSync_in),
    .VSync_in  (VSync_in),
    .R_out     (R_out),
    .G_out     (G_out),
    .B_out     (B_out),
    .HSync_out (HSync_out),
    .VSync_out (VSync_out)
  );

  typedef struct {
    int          cyc;
    logic        blank;
    logic [17:0] rgb;
    logic        line;
    logic        hs;
    logic        vs;
  } exp_t;

  exp_t  sb[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  int    fall_cnt = 0;
  int    last_id  = 0;
  int    last_len = 0;
  string phase    = "init";

  localparam logic [19:0] BLANK = {18'h0, 1'b1, 1'b1};

  task automatic t_check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] f_dim(input logic [5:0] x, input logic rep, input logic [1:0] mode);
    if (!rep || mode == 2'd0) return x;
    if (mode == 2'd1) return (x >> 1) + (x >> 2);
    if (mode == 2'd2) return x >> 1;
    return x >> 2;
  endfunction

  function automatic logic [17:0] f_pat(input int id, input int p);
    logic [5:0] r, g, b;
    if (id >= 100) return {6'h3C, 6'h3C, 6'h3C};
    r = 6'(p);
    g = 6'(p >> 6) ^ 6'(id);
    b = 6'(id * 5 + p * 3);
    return {r, g, b};
  endfunction

  function automatic logic [19:0] f_outs();
    return {R_out, G_out, B_out, HSync_out, VSync_out};
  endfunction

  task automatic t_monitor();
    exp_t        e;
    logic [19:0] want;
    while (sb.size() > 0 && sb[0].cyc < cyc) void'(sb.pop_front());
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      if (e.blank) want = BLANK;
      else want = {f_dim(e.rgb[17:12], e.line, scanlines),
                   f_dim(e.rgb[11:6],  e.line, scanlines),
                   f_dim(e.rgb[5:0],   e.line, scanlines), e.hs, e.vs};
      t_check($sformatf("%s@%0d", phase, cyc), f_outs(), want);
    end
  endtask

  // One ce_x2 period: an enabled clock followed by an idle clock.
  task automatic t_step(input logic x1);
    ce_x2 = 1'b1;
    ce_x1 = x1;
    @(posedge clk_sys); #1;
    ce_x2 = 1'b0;
    ce_x1 = 1'b0;
    cyc++;
    t_monitor();
    @(posedge clk_sys); #1;
  endtask

  task automatic t_idle(input int n);
    for (int p = 0; p < n; p++) begin
      {R_in, G_in, B_in} = 18'h2A95A;
      HSync_in = 1'b1;
      VSync_in = 1'b1;
      t_step(1'b1);
      t_check("idle_blank", f_outs(), BLANK);
      t_step(1'b0);
      t_check("idle_blank", f_outs(), BLANK);
    end
  endtask

  // Drives one input line; VSync_in is vs_a before pixel vtog, vs_b after.
  task automatic t_line(input int len, input int id, input int vtog,
                        input logic vs_a, input logic vs_b, input int rst_at);
    exp_t e;
    int   idx, pix;
    for (int p = 0; p < len; p++) begin
      if (p == rst_at) begin
        reset = 1'b1;
        #1;
        t_check("rst_async", f_outs(), BLANK);
        repeat (3) begin
          @(posedge clk_sys); #1;
          t_check("rst_hold", f_outs(), BLANK);
        end
        reset    = 1'b0;
        HSync_in = 1'b1;
        sb.delete();
        fall_cnt = 0;
        return;
      end
      {R_in, G_in, B_in} = f_pat(id, p);
      HSync_in = (p < HS_W) ? 1'b0 : 1'b1;
      VSync_in = (p < vtog) ? vs_a : vs_b;
      t_step(1'b1);
      if (p == 0) begin
        fall_cnt++;
        for (int k = 0; k < 2 * len; k++) begin
          e.cyc = cyc + 2 + k;
          if (fall_cnt < 2) begin
            e.blank = 1'b1; e.rgb = '0; e.line = 1'b0; e.hs = 1'b1; e.vs = 1'b1;
          end else begin
            idx     = k / last_len;
            pix     = k % last_len;
            e.blank = 1'b0;
            e.rgb   = f_pat(last_id, pix);
            e.line  = 1'(idx & 1);
            e.hs    = (pix >= HS_W);
            e.vs    = (((idx * last_len) / 2) < vtog) ? vs_a : vs_b;
          end
          sb.push_back(e);
        end
      end
      t_step(1'b0);
    end
    last_id  = id;
    last_len = (len > MAXLEN) ? MAXLEN : len;
  endtask

  initial begin
    reset     = 1'b1;
    ce_x1     = 1'b0;
    ce_x2     = 1'b0;
    scanlines = 2'd0;
    {R_in, G_in, B_in} = '0;
    HSync_in  = 1'b1;
    VSync_in  = 1'b1;
    repeat (3) @(posedge clk_sys);
    #1;
    t_check("reset_state", f_outs(), BLANK);
    reset = 1'b0;

    phase = "idle";
    t_idle(20);

    phase = "double";
    for (int i = 1; i <= 3; i++) t_line(400, i, 1000, 1'b1, 1'b1, -1);

    phase = "vsync";
    t_line(400, 2, 100, 1'b1, 1'b0, -1);
    t_line(400, 3, 150, 1'b0, 1'b1, -1);
    t_line(400, 4, 1000, 1'b1, 1'b1, -1);

    phase = "scan";
    scanlines = 2'd0;
    t_line(100, 100, 1000, 1'b1, 1'b1, -1);
    for (int m = 0; m < 4; m++) begin
      scanlines = 2'(m);
      t_line(100, 100, 1000, 1'b1, 1'b1, -1);
    end

    phase = "overrun";
    scanlines = 2'd2;
    t_line(1100, 5, 2000, 1'b1, 1'b1, -1);
    t_line(1030, 6, 2000, 1'b1, 1'b1, -1);
    t_line(400, 7, 2000, 1'b1, 1'b1, -1);

    phase = "lenchg";
    scanlines = 2'd1;
    t_line(380, 8, 1000, 1'b1, 1'b1, -1);
    t_line(420, 9, 1000, 1'b1, 1'b1, -1);
    t_line(380, 10, 1000, 1'b1, 1'b1, -1);
    t_line(420, 11, 1000, 1'b1, 1'b1, -1);
    t_line(380, 12, 1000, 1'b1, 1'b1, -1);

    phase = "midreset";
    scanlines = 2'd3;
    t_line(400, 13, 1000, 1'b1, 1'b1, 150);
    t_idle(10);
    t_line(400, 14, 1000, 1'b1, 1'b1, -1);
    t_line(400, 15, 1000, 1'b1, 1'b1, -1);
    t_line(400, 16, 1000, 1'b1, 1'b1, -1);

    phase = "tail";
    {R_in, G_in, B_in} = '0;
    HSync_in = 1'b1;
    t_step(1'b1);
    t_step(1'b0);
    t_check("sb_drain", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
